// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared state encoding, defaults and sequence helpers for the quadrature decoder
package quad_pkg;

    localparam int FILTER_LEN_DEF = 3;
    localparam int CNT_W_DEF      = 8;

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } quad_state_t;

    // Forward rotation S00->S01->S11->S10->S00 counts up.
    function automatic quad_state_t next_up(input quad_state_t s);
        case (s)
            S00:     next_up = S01;
            S01:     next_up = S11;
            S11:     next_up = S10;
            default: next_up = S00;
        endcase
    endfunction

    function automatic quad_state_t next_dn(input quad_state_t s);
        case (s)
            S00:     next_dn = S10;
            S10:     next_dn = S11;
            S11:     next_dn = S01;
            default: next_dn = S00;
        endcase
    endfunction

endpackage

// File: rtl/quad_input_filter.sv
// rtl/quad_input_filter.sv - one-bit synchronizer plus stability filter for a quadrature phase
module quad_input_filter
    import quad_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_valid
);

    localparam logic [3:0] LIM      = 4'(FILTER_LEN - 1);
    localparam logic [4:0] SETTLE_V = 5'(FILTER_LEN + 2);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_level;
    logic [3:0] r_cnt;
    logic [4:0] r_settle;

    // r_settle marks when a level present at reset release has had time to be accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_level  <= 1'b0;
            r_cnt    <= 4'd0;
            r_settle <= 5'd0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            if (r_settle != SETTLE_V) begin
                r_settle <= r_settle + 5'd1;
            end
            if (r_sync2 != r_level) begin
                if (r_cnt == LIM) begin
                    r_level <= r_sync2;
                    r_cnt   <= 4'd0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end else begin
                r_cnt <= 4'd0;
            end
        end
    end

    assign o_level = r_level;
    assign o_valid = (r_settle == SETTLE_V);

endmodule

// File: rtl/quad_step_decoder.sv
// rtl/quad_step_decoder.sv - filtered quadrature decoder with step pulse, direction, position count and error flag
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             en,
    input  logic             clr,
    output logic             step,
    output logic             dir,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    logic w_a;
    logic w_b;
    logic w_va;
    logic w_vb;
    logic [1:0] w_pair;
    logic [1:0] w_up_pair;
    logic [1:0] w_dn_pair;

    quad_state_t      r_state;
    logic             r_init;
    logic             r_step;
    logic             r_dir;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    quad_state_t      w_state_nxt;
    logic             w_init_nxt;
    logic             w_step_nxt;
    logic             w_dir_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_err_nxt;

    quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (quad_a),
        .o_level (w_a),
        .o_valid (w_va)
    );

    quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (quad_b),
        .o_level (w_b),
        .o_valid (w_vb)
    );

    assign w_pair    = {w_a, w_b};
    assign w_up_pair = next_up(r_state);
    assign w_dn_pair = next_dn(r_state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S00;
            r_init  <= 1'b0;
            r_step  <= 1'b0;
            r_dir   <= 1'b0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_init  <= w_init_nxt;
            r_step  <= w_step_nxt;
            r_dir   <= w_dir_nxt;
            r_count <= w_count_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // The state always follows the accepted pair; en only gates the visible step/count effects.
    always_comb begin
        w_state_nxt = r_state;
        w_init_nxt  = r_init;
        w_step_nxt  = 1'b0;
        w_dir_nxt   = r_dir;
        w_count_nxt = r_count;
        w_err_nxt   = r_err;
        if (!r_init) begin
            if (w_va && w_vb) begin
                w_state_nxt = quad_state_t'(w_pair);
                w_init_nxt  = 1'b1;
            end
        end else if (w_pair != r_state) begin
            w_state_nxt = quad_state_t'(w_pair);
            if (w_pair == w_up_pair) begin
                if (en) begin
                    w_step_nxt  = 1'b1;
                    w_dir_nxt   = 1'b1;
                    w_count_nxt = r_count + CNT_W'(1);
                end
            end else if (w_pair == w_dn_pair) begin
                if (en) begin
                    w_step_nxt  = 1'b1;
                    w_dir_nxt   = 1'b0;
                    w_count_nxt = r_count - CNT_W'(1);
                end
            end else begin
                w_err_nxt = 1'b1;
            end
        end
        if (clr) begin
            w_count_nxt = '0;
            w_err_nxt   = 1'b0;
        end
    end

    assign step  = r_step;
    assign dir   = r_dir;
    assign count = r_count;
    assign err   = r_err;

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb/tb_quad_step_decoder.sv - directed and randomized self-checking bench for quad_step_decoder
module tb_quad_step_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       quad_a = 1'b0;
    logic       quad_b = 1'b0;
    logic       en = 1'b1;
    logic       clr = 1'b0;
    logic       step;
    logic       dir;
    logic [7:0] count;
    logic       err;

    int checks = 0;
    int failures = 0;
    int steps_seen = 0;

    logic [1:0] m_pair = 2'b00;
    logic [7:0] m_count = 8'd0;
    logic       m_dir = 1'b0;
    logic       m_err = 1'b0;
    int         m_steps = 0;

    logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    quad_step_decoder #(.FILTER_LEN(3), .CNT_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .quad_a (quad_a),
        .quad_b (quad_b),
        .en     (en),
        .clr    (clr),
        .step   (step),
        .dir    (dir),
        .count  (count),
        .err    (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (step === 1'b1) steps_seen++;
    end

    function automatic int pos_of(input logic [1:0] p);
        case (p)
            2'b00:   pos_of = 0;
            2'b01:   pos_of = 1;
            2'b11:   pos_of = 2;
            default: pos_of = 3;
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Quadrature position arithmetic: +1 quarter is up, -1 is down, half a turn is illegal.
    task automatic model_apply(input logic [1:0] np, input logic en_v);
        int d;
        d = (pos_of(np) - pos_of(m_pair)) & 3;
        if (d == 1 && en_v) begin
            m_count = m_count + 8'd1;
            m_dir = 1'b1;
            m_steps++;
        end else if (d == 3 && en_v) begin
            m_count = m_count - 8'd1;
            m_dir = 1'b0;
            m_steps++;
        end else if (d == 2) begin
            m_err = 1'b1;
        end
        m_pair = np;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"}, int'(count), int'(m_count));
        check({tag, ".dir"}, int'(dir), int'(m_dir));
        check({tag, ".err"}, int'(err), int'(m_err));
        check({tag, ".steps"}, steps_seen, m_steps);
    endtask

    task automatic move(input logic [1:0] np, input logic en_v, input string tag);
        @(negedge clk);
        {quad_a, quad_b} = np;
        en = en_v;
        repeat (10) @(posedge clk);
        #1;
        model_apply(np, en_v);
        check_all(tag);
    endtask

    task automatic do_clr(input string tag);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_count = 8'd0;
        m_err = 1'b0;
        check({tag, ".count"}, int'(count), 0);
        check({tag, ".err"}, int'(err), 0);
    endtask

    initial begin
        int base_steps;
        logic [1:0] np;

        repeat (2) @(posedge clk);
        #1;
        check("reset.step", int'(step), 0);
        check("reset.dir", int'(dir), 0);
        check("reset.count", int'(count), 0);
        check("reset.err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_all("idle");

        @(negedge clk);
        quad_b = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("latency.step_early", int'(step), 0);
        @(posedge clk);
        #1;
        check("latency.step_at6", int'(step), 1);
        check("latency.count_at6", int'(count), 1);
        @(posedge clk);
        #1;
        check("latency.step_pulse", int'(step), 0);
        repeat (3) @(posedge clk);
        model_apply(2'b01, 1'b1);
        move(2'b11, 1'b1, "up2");
        move(2'b10, 1'b1, "up3");
        move(2'b00, 1'b1, "up4");
        check("up.count4", int'(count), 4);

        do_clr("clr1");
        move(2'b10, 1'b1, "wrap_down");
        check("wrap_down.255", int'(count), 255);
        move(2'b00, 1'b1, "wrap_up");
        check("wrap_up.0", int'(count), 0);

        base_steps = steps_seen;
        move(2'b11, 1'b1, "illegal");
        check("illegal.err", int'(err), 1);
        check("illegal.nostep", steps_seen, base_steps);
        do_clr("clr_err");
        move(2'b10, 1'b1, "after_illegal");
        move(2'b00, 1'b1, "back_home");

        @(negedge clk);
        quad_a = 1'b1;
        repeat (2) @(negedge clk);
        quad_a = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_all("glitch");
        move(2'b01, 1'b1, "post_glitch");

        do_clr("clr_en");
        move(2'b11, 1'b0, "en0_a");
        move(2'b10, 1'b0, "en0_b");
        move(2'b00, 1'b0, "en0_c");
        move(2'b01, 1'b1, "en1");
        check("en.count1", int'(count), 1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) do_clr("rand_clr");
            np = 2'($urandom_range(0, 3));
            move(np, 1'($urandom_range(0, 3) != 0), "rand");
        end

        do_clr("clr_rst");
        move(gray[(pos_of(m_pair) + 1) % 4], 1'b1, "pre_rst");
        np = gray[(pos_of(m_pair) + 1) % 4];
        @(negedge clk);
        {quad_a, quad_b} = np;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst.step", int'(step), 0);
        check("midrst.dir", int'(dir), 0);
        check("midrst.count", int'(count), 0);
        check("midrst.err", int'(err), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        m_pair = np;
        m_count = 8'd0;
        m_dir = 1'b0;
        m_err = 1'b0;
        check_all("post_rst");
        move(gray[(pos_of(m_pair) + 1) % 4], 1'b1, "post_rst_up");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quad_step_decoder.md
QUAD_STEP_DECODER -- requirements
Module: quad_step_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 3: consecutive stable synchronized samples required before an input level is accepted (range 1..15).
REQ-002 Parameter CNT_W, default 8: width of the position counter.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 quad_a  input  1  asynchronous quadrature phase A.
REQ-006 quad_b  input  1  asynchronous quadrature phase B.
REQ-007 en  input  1  step enable; 0 = track phase, emit nothing.
REQ-008 clr  input  1  synchronous clear of count and err.
REQ-009 step  output  1  one-cycle pulse per accepted legal transition.
REQ-010 dir  output  1  direction of last step; 1 = up, 0 = down.
REQ-011 count  output  CNT_W  signed-agnostic position counter.
REQ-012 err  output  1  sticky illegal-transition flag.

Function
REQ-013 Each phase SHALL pass a 2-flop synchronizer, then a filter accepting a new level only after FILTER_LEN consecutive equal samples differing from the accepted level.
REQ-014 Accepted {A,B} SHALL be decoded through states S00, S01, S11, S10.
REQ-015 Sequence S00->S01->S11->S10->S00 SHALL be up (dir=1); reverse SHALL be down (dir=0).
REQ-016 Step SHALL assert one cycle after the accepted pair changes; latency from first clk edge sampling a new pin level to step high SHALL be 2 + FILTER_LEN + 1 cycles (6 at default).
REQ-017 On a legal step with en=1: step=1, dir updated, count incremented (up) or decremented (down) modulo 2^CNT_W in the same cycle.
REQ-018 count SHALL wrap: all-ones + up -> 0; 0 + down -> all-ones; no saturation.
REQ-019 Both accepted bits changing in the same cycle SHALL set err, produce no step, leave dir/count unchanged, and move state to the new pair.
REQ-020 With en=0, state SHALL track accepted inputs; step, dir, count SHALL hold; illegal transitions SHALL still set err.
REQ-021 clr SHALL zero count and err next edge; clr beats a simultaneous step (count=0, step still pulses, dir updated).
REQ-022 The first accepted pair after reset SHALL initialise the state without step or err.
REQ-023 A glitch shorter than FILTER_LEN synchronized cycles SHALL produce no state change, step, or err.

Reset
REQ-024 rst high SHALL immediately force step=0, dir=0, count=0, err=0, synchronizers and filters to 0, filter counters to 0, init flag cleared.
REQ-025 rst asserted mid-filter or mid-step SHALL discard pending acceptance; no step on release until REQ-022 init completes.

Structure
REQ-026 Package quad_pkg SHALL hold the state encoding (S00, S01, S11, S10), FILTER_LEN and CNT_W defaults.
REQ-027 Sub-module quad_input_filter (synchronizer + stability counter, one bit) SHALL be instantiated once per phase.
REQ-028 Decode, direction, counter and err logic SHALL reside in quad_step_decoder; implementation 120-400 lines total.

Verification
REQ-029 After reset, pins hold 00 then drive 01,11,10,00 every 10 cycles, en=1 -> four step pulses, dir=1, count=4, err=0; first step 6 cycles after 01.
REQ-030 count=0, one down transition (00->10) -> count=255, dir=0; then 255 with one up -> count=0.
REQ-031 Pins jump 00->11 held 10 cycles -> err=1, no step, count unchanged; subsequent clr=1 one cycle -> err=0, count=0.
REQ-032 A pulses high for 2 cycles only (FILTER_LEN=3) -> no step, no err, state unchanged.
REQ-033 en=0 during 3 up transitions, then en=1 and one up -> single step, count=1.
REQ-034 rst pulsed 2 cycles after a pin change (mid-filter) -> all outputs 0 immediately; no step emitted for that change.
